branch_predictor_btb: RTL and testbench

Parametrised branch target buffer with per-entry 2-bit saturating direction counters and round-robin replacement. Fetch looks up the current PC combinationally to obtain a predicted next PC. Execute reports resolved branches and jumps, which update the table and raise a flush/redirect on misprediction. Sits between the IF-stage PC mux and the EX-stage branch resolution, and replaces the single-bit history LUT controller.

---
 rtl/branch_predictor_btb.sv | 198 +++++++++++++++++++
 tb/tb_branch_predictor_btb.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_btb.sv
// ---------------------------------------------------------------------------
// branch_predictor_btb
//
// Branch target buffer with a 2-bit (CNT_W) saturating direction counter per
// entry and round-robin replacement. The IF stage looks up fetch_pc
// combinationally to get a predicted next PC. The EX stage reports resolved
// branches/jumps, which train the table and raise flush/redirect_pc when the
// prediction carried down the pipeline turns out to be wrong.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous active-high reset, clears all state
//   fetch_pc         PC being fetched
//   pred_hit         fetch_pc matches a valid entry
//   pred_taken       hit and counter MSB set
//   pred_target      stored target when pred_taken, else fetch_pc+1
//   exe_valid        EX holds a resolved control-flow instruction
//   exe_is_jump      unconditional jump (0 = conditional branch)
//   exe_pc           PC of the resolved instruction
//   exe_taken        actual direction (treated as 1 for jumps)
//   exe_target       actual taken target
//   exe_pred_taken   pred_taken carried down the pipeline
//   exe_pred_target  pred_target carried down the pipeline
//   flush            misprediction this cycle; kill IF/ID
//   redirect_pc      correct next PC when flush=1, else 0
//   mispredict_count saturating count of flush cycles
// ---------------------------------------------------------------------------
module branch_predictor_btb #(
  parameter int ADDR_W  = 16,
  parameter int ENTRIES = 8,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              exe_valid,
  input  logic              exe_is_jump,
  input  logic [ADDR_W-1:0] exe_pc,
  input  logic              exe_taken,
  input  logic [ADDR_W-1:0] exe_target,
  input  logic              exe_pred_taken,
  input  logic [ADDR_W-1:0] exe_pred_target,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENTRIES - 1);

  // Table state
  logic              valid_q  [ENTRIES];
  logic [ADDR_W-1:0] tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];
  logic              jmp_q    [ENTRIES];
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [STAT_W-1:0] count_q, count_d;

  // Lookup / update match results
  logic              lookupHit;
  logic [IDX_W-1:0]  lookupIdx;
  logic              exeHit;
  logic [IDX_W-1:0]  exeIdx;

  // Single-entry write port, next-state values for the written entry
  logic              wrEn;
  logic [IDX_W-1:0]  wrIdx;
  logic [ADDR_W-1:0] tag_d;
  logic [ADDR_W-1:0] target_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              jmp_d;

  logic              effTaken;
  logic              mispredict;

  // Fetch-side associative match. Allocation only happens on a miss, so at
  // most one entry can match and the priority order of the loop is irrelevant.
  always_comb begin
    lookupHit = 1'b0;
    lookupIdx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (tag_q[i] == fetch_pc)) begin
        lookupHit = 1'b1;
        lookupIdx = IDX_W'(i);
      end
    end
  end

  // Execute-side match against the pre-update table (no bypass).
  always_comb begin
    exeHit = 1'b0;
    exeIdx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (tag_q[i] == exe_pc)) begin
        exeHit = 1'b1;
        exeIdx = IDX_W'(i);
      end
    end
  end

  assign pred_hit    = lookupHit;
  assign pred_taken  = lookupHit & cnt_q[lookupIdx][CNT_W-1];
  assign pred_target = pred_taken ? target_q[lookupIdx] : fetch_pc + ADDR_W'(1);

  // A jump is always taken regardless of what exe_taken says. A taken
  // prediction with the wrong target is a misprediction too.
  assign effTaken   = exe_taken | exe_is_jump;
  assign mispredict = exe_valid &
                      ((effTaken != exe_pred_taken) |
                       (effTaken & (exe_pred_target != exe_target)));

  assign flush       = mispredict;
  assign redirect_pc = mispredict ? (effTaken ? exe_target : exe_pc + ADDR_W'(1))
                                  : '0;
  assign mispredict_count = count_q;

  // Training: a hit updates the matching entry in place; a taken miss
  // allocates at the round-robin pointer, overwriting whatever is there.
  // Not-taken misses leave the table untouched so cold fall-through branches
  // do not pollute it.
  always_comb begin
    wrEn     = 1'b0;
    wrIdx    = exeIdx;
    tag_d    = exe_pc;
    target_d = target_q[exeIdx];
    cnt_d    = cnt_q[exeIdx];
    jmp_d    = jmp_q[exeIdx];
    rr_d     = rr_q;
    if (exe_valid) begin
      if (exeHit) begin
        wrEn = 1'b1;
        if (jmp_q[exeIdx] || exe_is_jump) begin
          cnt_d    = CNT_MAX;
          jmp_d    = 1'b1;
          target_d = exe_target;
        end else if (exe_taken) begin
          if (cnt_q[exeIdx] != CNT_MAX) begin
            cnt_d = cnt_q[exeIdx] + CNT_W'(1);
          end
          target_d = exe_target;
        end else begin
          if (cnt_q[exeIdx] != '0) begin
            cnt_d = cnt_q[exeIdx] - CNT_W'(1);
          end
        end
      end else if (effTaken) begin
        wrEn     = 1'b1;
        wrIdx    = rr_q;
        target_d = exe_target;
        jmp_d    = exe_is_jump;
        cnt_d    = exe_is_jump ? CNT_MAX : CNT_WEAK;
        rr_d     = (rr_q == IDX_LAST) ? '0 : rr_q + IDX_W'(1);
      end
    end
  end

  // Statistics counter sticks at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (mispredict && (count_q != '1)) begin
      count_d = count_q + STAT_W'(1);
    end
  end

  // State registers. An asynchronous reset during an update cycle wins, so
  // the pending write is simply lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= '0;
        jmp_q[i]    <= 1'b0;
      end
      rr_q    <= '0;
      count_q <= '0;
    end else begin
      if (wrEn) begin
        valid_q[wrIdx]  <= 1'b1;
        tag_q[wrIdx]    <= tag_d;
        target_q[wrIdx] <= target_d;
        cnt_q[wrIdx]    <= cnt_d;
        jmp_q[wrIdx]    <= jmp_d;
      end
      rr_q    <= rr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor_btb
//
// Drives directed and random fetch/resolve traffic into branch_predictor_btb.
// Each cycle the driver computes the expected outputs from a behavioural
// table model and queues them; an independent monitor pops one expectation
// per cycle on the falling edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_branch_predictor_btb;

  localparam int ENTRIES = 8;
  localparam int CNTMAX  = 3;
  localparam int AMASK   = 16'hFFFF;

  logic        clk;
  logic        reset;
  logic [15:0] fetch_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        exe_valid;
  logic        exe_is_jump;
  logic [15:0] exe_pc;
  logic        exe_taken;
  logic [15:0] exe_target;
  logic        exe_pred_taken;
  logic [15:0] exe_pred_target;
  logic        flush;
  logic [15:0] redirect_pc;
  logic [15:0] mispredict_count;

  branch_predictor_btb #(
    .ADDR_W (16),
    .ENTRIES(ENTRIES),
    .CNT_W  (2),
    .STAT_W (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_pc        (fetch_pc),
    .pred_hit        (pred_hit),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .exe_valid       (exe_valid),
    .exe_is_jump     (exe_is_jump),
    .exe_pc          (exe_pc),
    .exe_taken       (exe_taken),
    .exe_target      (exe_target),
    .exe_pred_taken  (exe_pred_taken),
    .exe_pred_target (exe_pred_target),
    .flush           (flush),
    .redirect_pc     (redirect_pc),
    .mispredict_count(mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    hit;
    int    taken;
    int    target;
    int    flushExp;
    int    redirect;
    int    count;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference table: a list of slots filled round-robin, plain integers.
  bit mValid [ENTRIES];
  int mTag   [ENTRIES];
  int mTarget[ENTRIES];
  int mCnt   [ENTRIES];
  bit mJmp   [ENTRIES];
  int mRr;
  int mCount;

  function automatic void clearModel();
    for (int i = 0; i < ENTRIES; i++) begin
      mValid[i] = 0; mTag[i] = 0; mTarget[i] = 0; mCnt[i] = 0; mJmp[i] = 0;
    end
    mRr = 0;
    mCount = 0;
  endfunction

  function automatic int findEntry(int pc);
    for (int i = 0; i < ENTRIES; i++)
      if (mValid[i] && mTag[i] == pc) return i;
    return -1;
  endfunction

  // Model prediction for a PC: returns {taken, target}.
  function automatic void modelPredict(int pc, output int hit, output int taken,
                                       output int target);
    int idx = findEntry(pc);
    hit    = (idx >= 0) ? 1 : 0;
    taken  = (idx >= 0 && mCnt[idx] >= 2) ? 1 : 0;
    target = taken ? mTarget[idx] : ((pc + 1) & AMASK);
  endfunction

  // One cycle of stimulus: drive, queue expectation, advance model.
  task automatic applyStimulus(string name, int fpc, bit v, bit isJ, int pc,
                               bit tk, int tgt, bit pTk, int pTgt);
    exp_t e;
    int   idx;
    bit   eff;
    bit   mis;
    @(posedge clk);
    #1;
    fetch_pc        = 16'(fpc);
    exe_valid       = v;
    exe_is_jump     = isJ;
    exe_pc          = 16'(pc);
    exe_taken       = tk;
    exe_target      = 16'(tgt);
    exe_pred_taken  = pTk;
    exe_pred_target = 16'(pTgt);

    e.name = name;
    modelPredict(fpc, e.hit, e.taken, e.target);
    eff = tk | isJ;
    mis = v && ((eff != pTk) || (eff && (pTgt != tgt)));
    e.flushExp = mis ? 1 : 0;
    e.redirect = mis ? (eff ? tgt : ((pc + 1) & AMASK)) : 0;
    e.count    = mCount;
    expQ.push_back(e);

    if (mis && mCount < 65535) mCount++;
    if (v) begin
      idx = findEntry(pc);
      if (idx >= 0) begin
        if (mJmp[idx] || isJ) begin
          mCnt[idx] = CNTMAX; mJmp[idx] = 1; mTarget[idx] = tgt;
        end else if (tk) begin
          if (mCnt[idx] < CNTMAX) mCnt[idx]++;
          mTarget[idx] = tgt;
        end else if (mCnt[idx] > 0) begin
          mCnt[idx]--;
        end
      end else if (eff) begin
        mValid[mRr] = 1; mTag[mRr] = pc; mTarget[mRr] = tgt;
        mJmp[mRr] = isJ; mCnt[mRr] = isJ ? CNTMAX : 2;
        mRr = (mRr + 1) % ENTRIES;
      end
    end
  endtask

  task automatic idleInputs();
    exe_valid = 0; exe_is_jump = 0; exe_pc = 0; exe_taken = 0;
    exe_target = 0; exe_pred_taken = 0; exe_pred_target = 0;
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1;
    idleInputs();
    reset = 1;
    #2;
    reset = 0;
    clearModel();
  endtask

  // An update is presented, then reset hits before the capturing edge.
  task automatic resetDuringUpdate(int pc, int tgt);
    @(posedge clk);
    #1;
    exe_valid = 1; exe_is_jump = 0; exe_pc = 16'(pc); exe_taken = 1;
    exe_target = 16'(tgt); exe_pred_taken = 1; exe_pred_target = 16'(tgt);
    #2;
    reset = 1;
    @(posedge clk);
    #1;
    idleInputs();
    reset = 0;
    clearModel();
  endtask

  task automatic checkOutput(string name, string field, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s.%s actual=0x%0h required=0x%0h", name, field, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e.name, "pred_hit",    int'(pred_hit),         e.hit);
        checkOutput(e.name, "pred_taken",  int'(pred_taken),       e.taken);
        checkOutput(e.name, "pred_target", int'(pred_target),      e.target);
        checkOutput(e.name, "flush",       int'(flush),            e.flushExp);
        checkOutput(e.name, "redirect_pc", int'(redirect_pc),      e.redirect);
        checkOutput(e.name, "count",       int'(mispredict_count), e.count);
      end
    end
  end

  initial begin
    int pc, tgt, fpc, h, t, pt;
    bit isJ, tk, pTk;
    reset = 1;
    fetch_pc = 0;
    idleInputs();
    clearModel();
    #12;
    reset = 0;

    // Reset state
    applyStimulus("reset_lookup", 16'h0010, 0, 0, 0, 0, 0, 0, 0);

    // BEQ allocate on mispredicted taken, then visible next cycle
    applyStimulus("beq_alloc", 16'h0020, 1, 0, 16'h0020, 1, 16'h0030, 0, 16'h0021);
    applyStimulus("beq_hit", 16'h0020, 0, 0, 0, 0, 0, 0, 0);

    // Counter training 10->11->11->10->01->00, same-cycle lookup sees old state
    applyStimulus("train_t1", 16'h0020, 1, 0, 16'h0020, 1, 16'h0030, 1, 16'h0030);
    applyStimulus("train_t2", 16'h0020, 1, 0, 16'h0020, 1, 16'h0030, 1, 16'h0030);
    applyStimulus("train_n1", 16'h0020, 1, 0, 16'h0020, 0, 16'h0030, 1, 16'h0030);
    applyStimulus("train_n2", 16'h0020, 1, 0, 16'h0020, 0, 16'h0030, 1, 16'h0030);
    applyStimulus("train_n3", 16'h0020, 1, 0, 16'h0020, 0, 16'h0030, 0, 16'h0021);
    applyStimulus("train_chk", 16'h0020, 0, 0, 0, 0, 0, 0, 0);

    // JAL allocates strongly taken; a jump report with exe_taken=0 keeps it
    applyStimulus("jal_alloc", 16'h0040, 1, 1, 16'h0040, 1, 16'h0100, 0, 16'h0041);
    applyStimulus("jal_hit", 16'h0040, 1, 1, 16'h0040, 0, 16'h0100, 1, 16'h0100);
    applyStimulus("jal_keep", 16'h0040, 0, 0, 0, 0, 0, 0, 0);

    // Wrong target on a correctly predicted taken branch
    applyStimulus("tgt_alloc", 16'h0080, 1, 0, 16'h0080, 1, 16'h0050, 0, 16'h0081);
    applyStimulus("tgt_wrong", 16'h0080, 1, 0, 16'h0080, 1, 16'h0060, 1, 16'h0050);
    applyStimulus("tgt_new", 16'h0080, 0, 0, 0, 0, 0, 0, 0);

    // PC wrap on not-taken redirect
    applyStimulus("wrap", 16'hFFFF, 1, 0, 16'hFFFF, 0, 16'h1234, 1, 16'h1234);

    // Round-robin eviction with ENTRIES+1 allocations
    pulseReset();
    for (int i = 0; i <= ENTRIES; i++)
      applyStimulus("rr_fill", 16'h0200 + i, 1, 0, 16'h0200 + i, 1, 16'h0400 + i,
                    0, 16'h0201 + i);
    applyStimulus("rr_evict0", 16'h0200, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("rr_last", 16'h0200 + ENTRIES, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("rr_slot1", 16'h0201, 1, 0, 16'h0300, 1, 16'h0500, 0, 16'h0301);
    applyStimulus("rr_evict1", 16'h0201, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("rr_keep2", 16'h0202, 0, 0, 0, 0, 0, 0, 0);

    // Reset landing on an update cycle discards the write
    resetDuringUpdate(16'h0090, 16'h0099);
    applyStimulus("rst_upd", 16'h0090, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("rst_old", 16'h0202, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic over a PC pool larger than the table
    for (int n = 0; n < 400; n++) begin
      fpc = 16'h1000 + int'($urandom_range(0, 11));
      pc  = 16'h1000 + int'($urandom_range(0, 11));
      tgt = 16'h2000 + int'($urandom_range(0, 3));
      isJ = ($urandom_range(0, 4) == 0);
      tk  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        modelPredict(pc, h, t, pt);
        pTk = t[0];
      end else begin
        pTk = 1'($urandom_range(0, 1));
        pt  = 16'h2000 + int'($urandom_range(0, 3));
      end
      applyStimulus("rand", fpc, ($urandom_range(0, 3) != 0), isJ, pc, tk, tgt, pTk, pt);
    end

    @(posedge clk);
    #1;
    idleInputs();
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    #1;
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
